// File: rtl/adder_datapath_control.sv
// ============================================================================
// Module   : adder_datapath_control
// Purpose  : Sequential two-operand adder: registered datapath plus FSM
//            controller. Optional macro ADC_SATURATE_EN clamps overflow to
//            all ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_datapath_control_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic i_irdy,
    output logic o_ld_a,
    output logic o_ld_b,
    output logic o_ld_r,
    output logic o_ordy
);
    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_ADD    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state_q;
    state_t w_state_d;
    logic   r_ordy_q;
    logic   w_ordy_d;

    always_comb begin
        w_state_d = r_state_q;
        w_ordy_d  = 1'b0;
        case (r_state_q)
            S_LOAD_A: if (i_irdy) w_state_d = S_LOAD_B;
            S_LOAD_B: if (i_irdy) w_state_d = S_ADD;
            S_ADD: begin
                w_state_d = S_DONE;
                w_ordy_d  = 1'b1;
            end
            S_DONE:   w_state_d = S_LOAD_A;
            default:  w_state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_LOAD_A;
            r_ordy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ordy_q  <= w_ordy_d;
        end
    end

    // Load enables act on the same edge that moves the FSM, so they are decoded
    // from the current state rather than registered.
    assign o_ld_a = (r_state_q == S_LOAD_A) && i_irdy;
    assign o_ld_b = (r_state_q == S_LOAD_B) && i_irdy;
    assign o_ld_r = (r_state_q == S_ADD);
    assign o_ordy = r_ordy_q;
endmodule

module adder_datapath_control_dp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_ld_a,
    input  logic             i_ld_b,
    input  logic             i_ld_r,
    output logic [WIDTH-1:0] o_dout
);
    logic [WIDTH-1:0] r_op_a_q;
    logic [WIDTH-1:0] r_op_b_q;
    logic [WIDTH-1:0] r_dout_q;
    logic [WIDTH-1:0] w_op_a_d;
    logic [WIDTH-1:0] w_op_b_d;
    logic [WIDTH-1:0] w_dout_d;
    logic [WIDTH-1:0] w_result;

`ifdef ADC_SATURATE_EN
    logic [WIDTH:0] w_sum;
    always_comb begin
        w_sum    = {1'b0, r_op_a_q} + {1'b0, r_op_b_q};
        w_result = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end
`else
    always_comb begin
        w_result = r_op_a_q + r_op_b_q;
    end
`endif

    always_comb begin
        w_op_a_d = i_ld_a ? i_din : r_op_a_q;
        w_op_b_d = i_ld_b ? i_din : r_op_b_q;
        w_dout_d = i_ld_r ? w_result : r_dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a_q <= '0;
            r_op_b_q <= '0;
            r_dout_q <= '0;
        end else begin
            r_op_a_q <= w_op_a_d;
            r_op_b_q <= w_op_b_d;
            r_dout_q <= w_dout_d;
        end
    end

    assign o_dout = r_dout_q;
endmodule

module adder_datapath_control #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             irdy,
    output logic [WIDTH-1:0] dout,
    output logic             ordy
);
    logic w_ld_a;
    logic w_ld_b;
    logic w_ld_r;

    adder_datapath_control_ctrl u_ctrl (
        .clk    (clk),
        .rst    (reset),
        .i_irdy (irdy),
        .o_ld_a (w_ld_a),
        .o_ld_b (w_ld_b),
        .o_ld_r (w_ld_r),
        .o_ordy (ordy)
    );

    adder_datapath_control_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (reset),
        .i_din  (din),
        .i_ld_a (w_ld_a),
        .i_ld_b (w_ld_b),
        .i_ld_r (w_ld_r),
        .o_dout (dout)
    );
endmodule

`default_nettype wire

// File: tb/tb_adder_datapath_control.sv
// ============================================================================
// Module   : tb_adder_datapath_control
// Purpose  : Self-checking bench for adder_datapath_control (directed plus
//            random operand pairs against an arithmetic reference).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_datapath_control;
    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             irdy;
    logic [WIDTH-1:0] dout;
    logic             ordy;

    int n_tests;
    int n_fail;
    int pulse_cnt;
    int exp_pulses;
    logic [WIDTH-1:0] last_dout;

    adder_datapath_control #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .irdy  (irdy),
        .dout  (dout),
        .ordy  (ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ordy === 1'b1) pulse_cnt++;

    function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
`ifdef ADC_SATURATE_EN
        if (s >= (longint'(1) << WIDTH)) s = (longint'(1) << WIDTH) - 1;
`else
        s = s % (longint'(1) << WIDTH);
`endif
        return s[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with idle gaps; junk is driven with random irdy
    // during ADD and DONE, which the design must drop.
    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int ga, input int gb);
        logic [WIDTH-1:0] e;
        e = ref_sum(a, b);
        irdy = 1'b0;
        for (int i = 0; i < ga; i++) begin
            din = WIDTH'($urandom);
            tick();
            check("gap_a_ordy", {31'd0, ordy}, 32'd0);
        end
        din = a; irdy = 1'b1;
        tick();
        check("cap_a_ordy", {31'd0, ordy}, 32'd0);
        irdy = 1'b0;
        for (int i = 0; i < gb; i++) begin
            din = WIDTH'($urandom);
            tick();
            check("gap_b_ordy", {31'd0, ordy}, 32'd0);
        end
        din = b; irdy = 1'b1;
        tick();
        check("cap_b_ordy", {31'd0, ordy}, 32'd0);
        check("cap_b_dout_hold", {16'd0, dout}, {16'd0, last_dout});
        irdy = 1'($urandom); din = WIDTH'($urandom);
        tick();
        check("res_ordy", {31'd0, ordy}, 32'd1);
        check("res_dout", {16'd0, dout}, {16'd0, e});
        irdy = 1'($urandom); din = WIDTH'($urandom);
        tick();
        check("post_ordy", {31'd0, ordy}, 32'd0);
        check("post_dout", {16'd0, dout}, {16'd0, e});
        irdy = 1'b0;
        exp_pulses++;
        last_dout = e;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; pulse_cnt = 0; exp_pulses = 0;
        last_dout = '0;
        reset = 1'b1; irdy = 1'b0; din = '0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_ordy", {31'd0, ordy}, 32'd0);

        // Single operand then idle: no result, opA must be held.
        din = 16'h0001; irdy = 1'b1;
        tick();
        irdy = 1'b0; din = 16'h0002;
        tick();
        check("one_op_ordy", {31'd0, ordy}, 32'd0);
        din = 16'h0003;
        tick();
        check("one_op_ordy2", {31'd0, ordy}, 32'd0);
        check("one_op_dout", {16'd0, dout}, 32'd0);
        repeat (3) tick();
        din = 16'h0002; irdy = 1'b1;
        tick();
        irdy = 1'b0;
        check("held_a_ordy0", {31'd0, ordy}, 32'd0);
        tick();
        check("held_a_ordy", {31'd0, ordy}, 32'd1);
        check("held_a_dout", {16'd0, dout}, 32'h0003);
        exp_pulses++;
        tick();
        check("held_a_ordy_fall", {31'd0, ordy}, 32'd0);
        repeat (3) tick();
        check("held_a_dout_hold", {16'd0, dout}, 32'h0003);
        last_dout = 16'h0003;

        send_pair(16'h1234, 16'h0FED, 0, 0);
        send_pair(16'hFFFF, 16'h0002, 1, 2);
        send_pair(16'h8000, 16'h8000, 0, 0);

        // Mid-operation reset discards the pending operand.
        din = 16'h0005; irdy = 1'b1;
        tick();
        irdy = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_dout", {16'd0, dout}, 32'd0);
        check("midrst_ordy", {31'd0, ordy}, 32'd0);
        last_dout = '0;
        send_pair(16'h0007, 16'h0001, 0, 0);

        // Reset during the ordy cycle.
        din = 16'h0010; irdy = 1'b1;
        tick();
        din = 16'h0020;
        tick();
        irdy = 1'b0;
        tick();
        check("rst_in_ordy_pre", {31'd0, ordy}, 32'd1);
        exp_pulses++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_in_ordy_ordy", {31'd0, ordy}, 32'd0);
        check("rst_in_ordy_dout", {16'd0, dout}, 32'd0);
        last_dout = '0;

        for (int k = 0; k < 100; k++) begin
            send_pair(WIDTH'($urandom), WIDTH'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        check("pulse_count", 32'(pulse_cnt), 32'(exp_pulses));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/adder_datapath_control.md
Name: adder_datapath_control

Overview:
- Sequential two-operand adder split into a registered datapath (operand registers, adder, result register) and an FSM controller.
- Operands arrive one per irdy strobe on a shared input bus. The result is presented on dout with a one-cycle ordy strobe.
- Sits between a simple valid-only producer and consumer; there is no backpressure.

Parameters:
- WIDTH, 16, bit width of din, dout and the internal operand/result registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising clk edge.
- din  input  WIDTH  operand data; sampled only when irdy=1 in a load state.
- irdy  input  1  input-ready strobe; din is valid this cycle.
- dout  output  WIDTH  registered sum; holds its value until the next result.
- ordy  output  1  registered output-ready strobe; high for exactly one cycle per result.

Behaviour:
- One clock domain. Reset is synchronous and active-high, and has priority over every other condition.
- Reset values: state=LOAD_A, opA=0, opB=0, dout=0, ordy=0.
- FSM states and transitions:
  - LOAD_A: if irdy, opA<=din and go to LOAD_B; else stay.
  - LOAD_B: if irdy, opB<=din and go to ADD; else stay. opA is held indefinitely while waiting.
  - ADD: dout<=opA+opB, ordy<=1, go to DONE. Unconditional, single cycle.
  - DONE: ordy<=0, go to LOAD_A.
- ordy is 0 in every state transition other than ADD->DONE.
- irdy is ignored in ADD and DONE; din presented then is dropped.
- Latency: on the clock edge after the edge that captures opB, dout updates and ordy rises. ordy falls one edge later.
- Throughput: a new operand pair can begin at the edge that leaves DONE. That is a minimum of 4 cycles per result with back-to-back irdy.
- Arithmetic: unsigned addition, modulo 2^WIDTH (carry-out discarded) unless the optional feature is enabled.
- dout is stable between results. It is not cleared when ordy falls.
- Reset mid-operation, in any state: partial operands are discarded and the outputs return to reset values on that edge. If ordy was high, it drops.
- irdy held high continuously: consecutive cycles load opA and then opB, so din values on two successive edges form a pair.
- Inputs are not registered. Timing is defined by din/irdy values at the rising edge.
- Implementation is split into a datapath submodule and a controller submodule, with load enables ldA, ldB and ldR driven by the controller.

Optional Feature:
- Macro ADC_SATURATE_EN.
- Defined: if opA+opB carries out of WIDTH bits, dout<=all ones (16'hFFFF at default width); otherwise the true sum.
- Undefined: wrap-around modulo 2^WIDTH (16'hFFFF+16'h0002 -> 16'h0001).
- Neither build changes latency or handshake behaviour.

Test Plan:
- Hold reset=1 for 5 cycles, then release -> dout=0, ordy=0. Then din=16'h0001 with irdy=1 for one cycle, followed by din=16'h0002 and then 16'h0003 with irdy=0 -> ordy stays 0 and dout stays 0.
- Pulse irdy on separate cycles: din=16'h0001, idle gaps, then din=16'h0002 -> ordy=1 for exactly one cycle, 1 edge after the second capture, with dout=16'h0003. dout holds 3 afterwards.
- Hold irdy=1 for 2 cycles with din=16'h1234 then 16'h0FED -> dout=16'h2221. Values driven while in ADD/DONE are ignored; the next pair starts from LOAD_A.
- Apply 16'hFFFF + 16'h0002 -> dout=16'h0001 without ADC_SATURATE_EN, and 16'hFFFF with it. ordy timing is identical in both builds.
- Load opA=16'h0005, assert reset for one cycle, then load 16'h0007 and 16'h0001 -> dout=16'h0008 (pre-reset operand discarded). Also assert reset during the ordy cycle -> ordy=0 on the next edge and dout=0.
- Run 100 random pairs with random irdy gaps -> each ordy pulse matches the reference sum, and the number of ordy pulses equals the number of pairs.
